// File: rtl/mod_updown_counter_if.sv
// Control and status bundle for mod_updown_counter.
// The master drives the count controls; the slave (the counter) returns count and bound flags.
interface mod_updown_counter_if #(
  parameter int unsigned WIDTH = 8
);
  logic             clear;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic             enable;
  logic             up_down;
  logic [WIDTH-1:0] counter_out;
  logic             terminal_count;
  logic             wrap_pulse;
  logic             overflow;

  modport master (
    output clear, load, load_value, enable, up_down,
    input  counter_out, terminal_count, wrap_pulse, overflow
  );

  modport slave (
    input  clear, load, load_value, enable, up_down,
    output counter_out, terminal_count, wrap_pulse, overflow
  );
endinterface

// File: rtl/mod_updown_counter.sv
// Modulo up/down counter with clear, clamped load, and wrap or saturate at the bounds.
// terminal_count is combinational so it can feed the next stage's enable directly.
module mod_updown_counter #(
  parameter int unsigned     WIDTH    = 8,
  parameter longint unsigned MODULUS  = 256,
  parameter bit              SATURATE = 1'b0
) (
  input logic                 clock,
  input logic                 reset,
  mod_updown_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(MODULUS - 64'd1);

  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] count_next;
  logic             wrap_q;
  logic             wrap_next;
  logic             overflow_q;
  logic             overflow_next;
  logic             at_top;
  logic             at_bottom;
  logic             bound_event;

  assign at_top      = (count == MAX_COUNT);
  assign at_bottom   = (count == '0);
  assign bound_event = bus.enable & ~bus.clear & ~bus.load &
                       (bus.up_down ? at_top : at_bottom);

  // Explicit bound compare keeps arithmetic modulo MODULUS rather than 2**WIDTH.
  always_comb begin
    count_next    = count;
    overflow_next = overflow_q;
    wrap_next     = 1'b0;
    if (bus.clear) begin
      count_next    = '0;
      overflow_next = 1'b0;
    end else if (bus.load) begin
      count_next = (bus.load_value > MAX_COUNT) ? MAX_COUNT : bus.load_value;
    end else if (bus.enable) begin
      if (bound_event) begin
        wrap_next     = 1'b1;
        overflow_next = 1'b1;
        if (SATURATE)
          count_next = count;
        else
          count_next = bus.up_down ? '0 : MAX_COUNT;
      end else begin
        count_next = bus.up_down ? count + WIDTH'(1) : count - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count      <= '0;
      wrap_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      count      <= count_next;
      wrap_q     <= wrap_next;
      overflow_q <= overflow_next;
    end
  end

  assign bus.counter_out    = count;
  assign bus.terminal_count = bound_event;
  assign bus.wrap_pulse     = wrap_q;
  assign bus.overflow       = overflow_q;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Drives three counter configurations (mod-10 wrap, mod-10 saturate, mod-256 wrap) from one
// stimulus stream and compares each against an arithmetic reference model.
module tb_mod_updown_counter;

  logic       clock = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0, ld = 1'b0, en = 1'b0, ud = 1'b1;
  logic [7:0] lv = '0;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clock = ~clock;

  mod_updown_counter_if #(.WIDTH(4)) bus_a ();
  mod_updown_counter_if #(.WIDTH(4)) bus_s ();
  mod_updown_counter_if #(.WIDTH(8)) bus_w ();

  assign bus_a.clear = clr;  assign bus_a.load = ld;  assign bus_a.enable = en;
  assign bus_a.up_down = ud; assign bus_a.load_value = lv[3:0];
  assign bus_s.clear = clr;  assign bus_s.load = ld;  assign bus_s.enable = en;
  assign bus_s.up_down = ud; assign bus_s.load_value = lv[3:0];
  assign bus_w.clear = clr;  assign bus_w.load = ld;  assign bus_w.enable = en;
  assign bus_w.up_down = ud; assign bus_w.load_value = lv;

  mod_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) dut_a (
    .clock(clock), .reset(rst_n), .bus(bus_a));
  mod_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1)) dut_s (
    .clock(clock), .reset(rst_n), .bus(bus_s));
  mod_updown_counter #(.WIDTH(8), .MODULUS(256), .SATURATE(1'b0)) dut_w (
    .clock(clock), .reset(rst_n), .bus(bus_w));

  logic [7:0] cnt_o [3];
  logic [2:0] tc_o, wp_o, ov_o;
  assign cnt_o[0] = {4'b0, bus_a.counter_out};
  assign cnt_o[1] = {4'b0, bus_s.counter_out};
  assign cnt_o[2] = bus_w.counter_out;
  assign tc_o = {bus_w.terminal_count, bus_s.terminal_count, bus_a.terminal_count};
  assign wp_o = {bus_w.wrap_pulse, bus_s.wrap_pulse, bus_a.wrap_pulse};
  assign ov_o = {bus_w.overflow, bus_s.overflow, bus_a.overflow};

  // Reference model: plain integer arithmetic per configuration.
  int mod_m [3] = '{10, 10, 256};
  bit sat_m [3] = '{1'b0, 1'b1, 1'b0};
  int wid_m [3] = '{4, 4, 8};
  int mc [3] = '{0, 0, 0};
  bit mw [3] = '{1'b0, 1'b0, 1'b0};
  bit mo [3] = '{1'b0, 1'b0, 1'b0};

  task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic check_regs();
    for (int unsigned i = 0; i < 3; i++) begin
      check($sformatf("count[%0d]", i), cnt_o[i], mc[i]);
      check($sformatf("wrap[%0d]", i), wp_o[i], mw[i]);
      check($sformatf("ovf[%0d]", i), ov_o[i], mo[i]);
    end
  endtask

  task automatic step(input bit c, input bit l, input bit e, input bit u, input logic [7:0] v);
    int m, lvt, nc;
    bit bnd;
    clr = c; ld = l; en = e; ud = u; lv = v;
    #1;
    for (int unsigned i = 0; i < 3; i++) begin
      m   = mod_m[i];
      lvt = int'(v) % (1 << wid_m[i]);
      bnd = e && !c && !l && (u ? (mc[i] == m - 1) : (mc[i] == 0));
      check($sformatf("tc[%0d]", i), tc_o[i], bnd);
      if (c) begin
        nc = 0; mo[i] = 1'b0; mw[i] = 1'b0;
      end else if (l) begin
        nc = (lvt > m - 1) ? m - 1 : lvt; mw[i] = 1'b0;
      end else if (e) begin
        mw[i] = bnd;
        if (bnd) mo[i] = 1'b1;
        if (u) nc = sat_m[i] ? ((mc[i] + 1 > m - 1) ? m - 1 : mc[i] + 1) : (mc[i] + 1) % m;
        else   nc = sat_m[i] ? ((mc[i] - 1 < 0) ? 0 : mc[i] - 1) : (mc[i] - 1 + m) % m;
      end else begin
        nc = mc[i]; mw[i] = 1'b0;
      end
      mc[i] = nc;
    end
    @(posedge clock); #1;
    check_regs();
  endtask

  task automatic model_reset();
    for (int unsigned i = 0; i < 3; i++) begin
      mc[i] = 0; mw[i] = 1'b0; mo[i] = 1'b0;
    end
  endtask

  initial begin
    #3;
    check_regs();
    @(posedge clock); #2;
    rst_n = 1'b1;

    repeat (12) step(0, 0, 1, 1, 8'd0);
    check("a_after12", cnt_o[0], 2);
    check("a_ovf_after12", ov_o[0], 1);
    step(1, 0, 0, 1, 8'd0);
    repeat (3) step(0, 0, 1, 0, 8'd0);
    check("a_down3", cnt_o[0], 7);
    step(1, 0, 1, 0, 8'd0);
    check("a_clear_ovf", ov_o[0], 0);

    repeat (12) step(0, 0, 1, 1, 8'd0);
    check("s_hold_top", cnt_o[1], 9);
    repeat (12) step(0, 0, 1, 0, 8'd0);
    check("s_hold_bottom", cnt_o[1], 0);
    check("s_ovf", ov_o[1], 1);

    step(0, 1, 0, 1, 8'd14);
    check("a_load_clamp", cnt_o[0], 9);
    step(0, 1, 1, 1, 8'd3);
    check("a_load_over_enable", cnt_o[0], 3);
    step(1, 1, 0, 1, 8'd5);
    check("a_clear_over_load", cnt_o[0], 0);

    step(0, 1, 0, 1, 8'd255);
    step(0, 0, 1, 1, 8'd0);
    check("w_wrap_up", cnt_o[2], 0);
    step(0, 0, 1, 0, 8'd0);
    check("w_wrap_down", cnt_o[2], 255);

    step(1, 0, 0, 1, 8'd0);
    repeat (7) step(0, 0, 1, 1, 8'd0);
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_regs();
    @(posedge clock); #1;
    check_regs();
    #1 rst_n = 1'b1;

    repeat (600) begin
      step($urandom_range(0, 24) == 0, $urandom_range(0, 14) == 0,
           $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
           8'($urandom_range(0, 255)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mod_updown_counter.md
# mod_updown_counter

Parametrised modulo up/down counter, the general-purpose successor to the fixed 4-bit up-counter. It adds configurable width and modulus, a count direction, synchronous clear and parallel load, and a wrap or saturate mode. It also provides terminal-count, wrap-pulse and sticky overflow outputs for cascading, e.g. BCD digit chains, timers and event counters. It sits beside datapath control logic and is cascaded through `terminal_count` into the next stage's `enable`.

## Interface
- `WIDTH`, default 8: counter register width in bits; legal range 1..32.
- `MODULUS`, default 256: count range is 0..MODULUS-1; legal range 2..2**WIDTH.
- `SATURATE`, default 0: 0 = wrap at the bounds; 1 = hold at the bounds.
- `clock`  input  1: single clock; all state updates on the rising edge.
- `reset`  input  1: asynchronous, active-low reset (0 = in reset).
- `clear`  input  1: synchronous, active-high clear to 0.
- `load`  input  1: synchronous, active-high parallel load.
- `load_value`  input  WIDTH: value taken when `load`=1.
- `enable`  input  1: active-high count enable.
- `up_down`  input  1: 1 = count up, 0 = count down.
- `counter_out`  output  WIDTH: registered count value.
- `terminal_count`  output  1: combinational; indicates the next enabled count crosses a bound.
- `wrap_pulse`  output  1: registered one-cycle pulse after a bound event.
- `overflow`  output  1: registered sticky flag for bound events.

## Operation
- Reset (`reset`=0) forces, immediately and without a clock, `counter_out`=0, `wrap_pulse`=0 and `overflow`=0. These are the reset values of all registered outputs.
- Synchronous priority at each rising edge, highest first: clear, then load, then enable, then hold.
- **clear**
  - Sets `counter_out`=0 and `overflow`=0.
  - `wrap_pulse` is 0 next cycle.
- **load**
  - Sets `counter_out` = min(`load_value`, MODULUS-1).
  - Out-of-range loads are clamped, never wrapped.
  - No bound event occurs; `overflow` is unchanged.
- **enable, up direction** (`up_down`=1)
  - If `counter_out` < MODULUS-1, increment by 1.
  - At MODULUS-1, a bound event occurs: the next value is 0 if SATURATE=0, or MODULUS-1 if SATURATE=1.
- **enable, down direction** (`up_down`=0)
  - If `counter_out` > 0, decrement by 1.
  - At 0, a bound event occurs: the next value is MODULUS-1 if SATURATE=0, or 0 if SATURATE=1.
- **Bound events**
  - Set `wrap_pulse`=1 for exactly the following cycle and set `overflow`=1.
  - `overflow` stays set until the next clear or reset.
- Hold: `counter_out` and `overflow` are unchanged; `wrap_pulse` is 0.
- `terminal_count` = `enable` & ~`clear` & ~`load` & ((`up_down` & `counter_out`==MODULUS-1) | (~`up_down` & `counter_out`==0)).
  - It is identical in wrap and saturate modes.
- **Arithmetic**
  - Increment and decrement are performed modulo MODULUS, never modulo 2**WIDTH.
  - When MODULUS=2**WIDTH, the natural binary wrap is the required result.
- Direction may change on any cycle; the new direction takes effect on that edge.

## Timing
- Latency from control input to `counter_out` is one clock edge; there is no pipeline.
- `terminal_count` is combinational from `counter_out`, `enable`, `up_down`, `clear` and `load`, with the same cycle validity. It is intended to drive a downstream `enable` directly.
- `wrap_pulse` rises the cycle after `terminal_count` was high on an edge, coincident with the wrapped or saturated `counter_out`.
- **Simultaneous events**
  - clear+load: clear wins.
  - load+enable at a bound: load wins; no `wrap_pulse`; `overflow` is unchanged.
  - clear+enable at a bound: clear wins; `overflow`=0.
- Reset asserted mid-count drops all registered outputs to 0 within the same cycle, asynchronously.
- Reset deassertion is synchronised upstream. The first counting edge is the first rising `clock` with `reset`=1.

## Test plan
- WIDTH=4, MODULUS=10, SATURATE=0.
  - Stimulus: reset, then `enable`=1, `up_down`=1 for 12 edges.
  - Required: `counter_out` runs 1..9, 0, 1, 2.
  - Required: `terminal_count`=1 only while at 9; `wrap_pulse`=1 only in the cycle showing 0; `overflow`=1 thereafter.
- Same configuration, `up_down`=0 from 0.
  - Required: next value 9 with `wrap_pulse`=1; then 8, 7.
  - Required: assert `clear`, and `counter_out`=0 with `overflow`=0 on the next edge.
- SATURATE=1, MODULUS=10.
  - Stimulus: count up past 9 for 3 edges, then count down past 0.
  - Required: `counter_out` holds at 9, then holds at 0; `wrap_pulse` is high one cycle per saturated edge; `overflow` stays 1.
- Load clamp and priority.
  - Stimulus: `load_value`=14 with `load`=1 → required `counter_out`=9.
  - Stimulus: `load`=1 with `enable`=1 at count 9, `load_value`=3 → required 3, no `wrap_pulse`.
  - Stimulus: `clear`+`load` together → required 0.
- Asynchronous reset mid-count.
  - Stimulus: at count 7, drive `reset`=0 between clock edges.
  - Required: `counter_out`, `wrap_pulse` and `overflow` read 0 before the next edge and stay 0 until release.
- WIDTH=8, MODULUS=256.
  - Stimulus: load 255, enable up → required 0 with `wrap_pulse`=1.
  - Stimulus: then enable down → required 255 with `wrap_pulse`=1.
